// File: rtl/axi_arbiter_if.sv
// ============================================================================
// axi_arbiter_if : AXI4 bundle (addr 32, data 32, len 8, id 4) for the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_arbiter_if;
   // read address
   logic        arvalid;
   logic        arready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   // read data
   logic        rvalid;
   logic        rready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   // write address
   logic        awvalid;
   logic        awready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   // write data
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   // write response
   logic        bvalid;
   logic        bready;
   logic [3:0]  bid;
   logic [1:0]  bresp;

   modport master (
      output arvalid, arid, araddr, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rid, rdata, rresp, rlast,
      output rready,
      output awvalid, awid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready
   );

   modport slave (
      input  arvalid, arid, araddr, arlen, arsize, arburst,
      output arready,
      output rvalid, rid, rdata, rresp, rlast,
      input  rready,
      input  awvalid, awid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready
   );
endinterface

`default_nettype wire

// File: rtl/axi_arbiter.sv
// ============================================================================
// axi_arbiter : IFU/LSU to single AXI4 master, one transaction outstanding.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin between the two read masters.
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_arbiter (
   input  logic          clock_i,
   input  logic          reset_i,
   axi_arbiter_if.slave  ifu_if,
   axi_arbiter_if.slave  lsu_if,
   axi_arbiter_if.master io_master_if
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_IFU = 2'd1,
      RD_LSU = 2'd2,
      WR_LSU = 2'd3
   } state_e;

   state_e state_q, state_d;
   state_e state_out;
   logic   ar_done_q, ar_done_d;
   logic   aw_done_q, aw_done_d;
   logic   w_done_q,  w_done_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic   prefer_ifu_q, prefer_ifu_d;
`endif

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         ar_done_q    <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         prefer_ifu_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ar_done_q    <= ar_done_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
`ifdef ARB_ROUND_ROBIN_EN
         prefer_ifu_q <= prefer_ifu_d;
`endif
      end
   end

   // Next-state: grants are taken only from IDLE, which gives the one-cycle turnaround.
   always_comb begin
      state_d   = state_q;
      ar_done_d = ar_done_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
`ifdef ARB_ROUND_ROBIN_EN
      prefer_ifu_d = prefer_ifu_q;
`endif
      case (state_q)
         IDLE: begin
            ar_done_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (lsu_if.awvalid) begin
               state_d = WR_LSU;
            end
`ifdef ARB_ROUND_ROBIN_EN
            else if (lsu_if.arvalid && ifu_if.arvalid) begin
               state_d      = prefer_ifu_q ? RD_IFU : RD_LSU;
               prefer_ifu_d = ~prefer_ifu_q;
            end else if (lsu_if.arvalid) begin
               state_d      = RD_LSU;
               prefer_ifu_d = 1'b1;
            end else if (ifu_if.arvalid) begin
               state_d      = RD_IFU;
               prefer_ifu_d = 1'b0;
            end
`else
            else if (lsu_if.arvalid) begin
               state_d = RD_LSU;
            end else if (ifu_if.arvalid) begin
               state_d = RD_IFU;
            end
`endif
         end
         RD_IFU, RD_LSU: begin
            if (io_master_if.arvalid && io_master_if.arready) begin
               ar_done_d = 1'b1;
            end
            if (io_master_if.rvalid && io_master_if.rready && io_master_if.rlast) begin
               state_d   = IDLE;
               ar_done_d = 1'b0;
            end
         end
         WR_LSU: begin
            if (io_master_if.awvalid && io_master_if.awready) begin
               aw_done_d = 1'b1;
            end
            if (io_master_if.wvalid && io_master_if.wready) begin
               w_done_d = 1'b1;
            end
            if (io_master_if.bvalid && io_master_if.bready) begin
               state_d   = IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Routing; reset forces the IDLE view so every valid/ready drops in the reset cycle itself.
   always_comb begin
      state_out = reset_i ? IDLE : state_q;

      io_master_if.arvalid = 1'b0;
      io_master_if.arid    = 4'd0;
      io_master_if.araddr  = 32'd0;
      io_master_if.arlen   = 8'd0;
      io_master_if.arsize  = 3'd0;
      io_master_if.arburst = 2'd0;
      io_master_if.rready  = 1'b0;
      io_master_if.awvalid = 1'b0;
      io_master_if.awid    = 4'd0;
      io_master_if.awaddr  = 32'd0;
      io_master_if.awlen   = 8'd0;
      io_master_if.awsize  = 3'd0;
      io_master_if.awburst = 2'b01;
      io_master_if.wvalid  = 1'b0;
      io_master_if.wdata   = 32'd0;
      io_master_if.wstrb   = 4'd0;
      io_master_if.wlast   = 1'b1;
      io_master_if.bready  = 1'b0;

      ifu_if.arready = 1'b0;
      ifu_if.rvalid  = 1'b0;
      ifu_if.rid     = 4'd0;
      ifu_if.rdata   = 32'd0;
      ifu_if.rresp   = 2'd0;
      ifu_if.rlast   = 1'b0;
      ifu_if.awready = 1'b0;
      ifu_if.wready  = 1'b0;
      ifu_if.bvalid  = 1'b0;
      ifu_if.bid     = 4'd0;
      ifu_if.bresp   = 2'd0;

      lsu_if.arready = 1'b0;
      lsu_if.rvalid  = 1'b0;
      lsu_if.rid     = 4'd0;
      lsu_if.rdata   = 32'd0;
      lsu_if.rresp   = 2'd0;
      lsu_if.rlast   = 1'b0;
      lsu_if.awready = 1'b0;
      lsu_if.wready  = 1'b0;
      lsu_if.bvalid  = 1'b0;
      lsu_if.bid     = 4'd0;
      lsu_if.bresp   = 2'd0;

      case (state_out)
         RD_IFU: begin
            io_master_if.arvalid = ifu_if.arvalid & ~ar_done_q;
            io_master_if.araddr  = ifu_if.araddr;
            io_master_if.arlen   = ifu_if.arlen;
            io_master_if.arsize  = 3'b010;
            io_master_if.arburst = ifu_if.arburst;
            ifu_if.arready       = io_master_if.arready & ~ar_done_q;
            ifu_if.rvalid        = io_master_if.rvalid;
            ifu_if.rid           = io_master_if.rid;
            ifu_if.rdata         = io_master_if.rdata;
            ifu_if.rresp         = io_master_if.rresp;
            ifu_if.rlast         = io_master_if.rlast;
            io_master_if.rready  = ifu_if.rready;
         end
         RD_LSU: begin
            io_master_if.arvalid = lsu_if.arvalid & ~ar_done_q;
            io_master_if.araddr  = lsu_if.araddr;
            io_master_if.arlen   = lsu_if.arlen;
            io_master_if.arsize  = lsu_if.arsize;
            io_master_if.arburst = lsu_if.arburst;
            lsu_if.arready       = io_master_if.arready & ~ar_done_q;
            lsu_if.rvalid        = io_master_if.rvalid;
            lsu_if.rid           = io_master_if.rid;
            lsu_if.rdata         = io_master_if.rdata;
            lsu_if.rresp         = io_master_if.rresp;
            lsu_if.rlast         = io_master_if.rlast;
            io_master_if.rready  = lsu_if.rready;
         end
         WR_LSU: begin
            io_master_if.awvalid = lsu_if.awvalid & ~aw_done_q;
            io_master_if.awaddr  = lsu_if.awaddr;
            io_master_if.awsize  = lsu_if.awsize;
            lsu_if.awready       = io_master_if.awready & ~aw_done_q;
            io_master_if.wvalid  = lsu_if.wvalid & ~w_done_q;
            io_master_if.wdata   = lsu_if.wdata;
            io_master_if.wstrb   = lsu_if.wstrb;
            lsu_if.wready        = io_master_if.wready & ~w_done_q;
            lsu_if.bvalid        = io_master_if.bvalid;
            lsu_if.bid           = io_master_if.bid;
            lsu_if.bresp         = io_master_if.bresp;
            io_master_if.bready  = lsu_if.bready;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_arbiter.sv
// ============================================================================
// tb_axi_arbiter : directed self-checking bench for axi_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   bit   ifu_first;

   always #5 clk = ~clk;

   axi_arbiter_if ifu_bus ();
   axi_arbiter_if lsu_bus ();
   axi_arbiter_if io_bus ();

   axi_arbiter dut (
      .clock_i      (clk),
      .reset_i      (rst),
      .ifu_if       (ifu_bus),
      .lsu_if       (lsu_bus),
      .io_master_if (io_bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic serve_ar(input bit is_lsu, input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      while (io_bus.arvalid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("ar_wait", 32'(n < 20), 32'd1);
      check("araddr", io_bus.araddr, addr);
      check("arlen", 32'(io_bus.arlen), 32'(len));
      io_bus.arready = 1'b1;
      #1;
      check("arready_gnt", 32'(is_lsu ? lsu_bus.arready : ifu_bus.arready), 32'd1);
      check("arready_other", 32'(is_lsu ? ifu_bus.arready : lsu_bus.arready), 32'd0);
      step();
      io_bus.arready = 1'b0;
      #1;
      check("arvalid_hold", 32'(io_bus.arvalid), 32'd0);
      if (is_lsu) lsu_bus.arvalid = 1'b0;
      else        ifu_bus.arvalid = 1'b0;
   endtask

   task automatic serve_r(input bit is_lsu, input logic [7:0] len, input logic [31:0] base,
                          input int stall_at, input int stall_n);
      int got = 0;
      for (int b = 0; b <= int'(len); b++) begin
         io_bus.rvalid = 1'b1;
         io_bus.rdata  = base + 32'(b);
         io_bus.rresp  = 2'b00;
         io_bus.rlast  = (b == int'(len));
         if (b == stall_at) begin
            if (is_lsu) lsu_bus.rready = 1'b0;
            else        ifu_bus.rready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               #1;
               check("stall_rready", 32'(io_bus.rready), 32'd0);
               step();
            end
            if (is_lsu) lsu_bus.rready = 1'b1;
            else        ifu_bus.rready = 1'b1;
         end
         #1;
         check("rvalid_gnt", 32'(is_lsu ? lsu_bus.rvalid : ifu_bus.rvalid), 32'd1);
         check("rdata", is_lsu ? lsu_bus.rdata : ifu_bus.rdata, base + 32'(b));
         check("rresp", 32'(is_lsu ? lsu_bus.rresp : ifu_bus.rresp), 32'd0);
         check("rlast", 32'(is_lsu ? lsu_bus.rlast : ifu_bus.rlast), 32'(b == int'(len)));
         check("rvalid_other", 32'(is_lsu ? ifu_bus.rvalid : lsu_bus.rvalid), 32'd0);
         check("rready_fwd", 32'(io_bus.rready), 32'd1);
         if (is_lsu ? (lsu_bus.rvalid && lsu_bus.rready) : (ifu_bus.rvalid && ifu_bus.rready))
            got++;
         step();
      end
      io_bus.rvalid = 1'b0;
      io_bus.rlast  = 1'b0;
      #1;
      check("beats", 32'(got), 32'(len) + 32'd1);
      check("rd_idle", 32'(dut.state_q), 32'd0);
   endtask

   task automatic serve_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      while (io_bus.awvalid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("aw_wait", 32'(n < 20), 32'd1);
      check("awaddr", io_bus.awaddr, addr);
      check("awlen", 32'(io_bus.awlen), 32'd0);
      check("awburst", 32'(io_bus.awburst), 32'd1);
      check("wvalid", 32'(io_bus.wvalid), 32'd1);
      check("wdata", io_bus.wdata, data);
      check("wstrb", 32'(io_bus.wstrb), 32'(strb));
      check("wlast", 32'(io_bus.wlast), 32'd1);
      check("wr_no_ar", 32'(io_bus.arvalid), 32'd0);
      io_bus.awready = 1'b1;
      io_bus.wready  = 1'b1;
      #1;
      check("lsu_awready", 32'(lsu_bus.awready), 32'd1);
      check("lsu_wready", 32'(lsu_bus.wready), 32'd1);
      check("wr_lsu_arready", 32'(lsu_bus.arready), 32'd0);
      step();
      io_bus.awready = 1'b0;
      io_bus.wready  = 1'b0;
      #1;
      check("awvalid_hold", 32'(io_bus.awvalid), 32'd0);
      check("wvalid_hold", 32'(io_bus.wvalid), 32'd0);
      lsu_bus.awvalid = 1'b0;
      lsu_bus.wvalid  = 1'b0;
      step();
      check("bvalid_early", 32'(lsu_bus.bvalid), 32'd0);
      io_bus.bvalid = 1'b1;
      io_bus.bresp  = 2'b00;
      #1;
      check("lsu_bvalid", 32'(lsu_bus.bvalid), 32'd1);
      check("lsu_bresp", 32'(lsu_bus.bresp), 32'd0);
      check("bready_fwd", 32'(io_bus.bready), 32'd1);
      check("wr_no_ar_b", 32'(io_bus.arvalid), 32'd0);
      step();
      io_bus.bvalid = 1'b0;
      #1;
      check("lsu_bvalid_once", 32'(lsu_bus.bvalid), 32'd0);
      check("wr_idle", 32'(dut.state_q), 32'd0);
   endtask

   task automatic lsu_rd_req(input logic [31:0] addr, input logic [7:0] len);
      lsu_bus.arvalid = 1'b1;
      lsu_bus.araddr  = addr;
      lsu_bus.arlen   = len;
      lsu_bus.arsize  = 3'b010;
      lsu_bus.arburst = 2'b01;
   endtask

   task automatic ifu_rd_req(input logic [31:0] addr, input logic [7:0] len);
      ifu_bus.arvalid = 1'b1;
      ifu_bus.araddr  = addr;
      ifu_bus.arlen   = len;
      ifu_bus.arburst = 2'b01;
   endtask

   initial begin
      ifu_bus.arvalid = 0; ifu_bus.arid = 0; ifu_bus.araddr = 0; ifu_bus.arlen = 0;
      ifu_bus.arsize = 0; ifu_bus.arburst = 0; ifu_bus.rready = 1;
      ifu_bus.awvalid = 0; ifu_bus.awid = 0; ifu_bus.awaddr = 0; ifu_bus.awlen = 0;
      ifu_bus.awsize = 0; ifu_bus.awburst = 0; ifu_bus.wvalid = 0; ifu_bus.wdata = 0;
      ifu_bus.wstrb = 0; ifu_bus.wlast = 0; ifu_bus.bready = 1;
      lsu_bus.arvalid = 0; lsu_bus.arid = 0; lsu_bus.araddr = 0; lsu_bus.arlen = 0;
      lsu_bus.arsize = 0; lsu_bus.arburst = 0; lsu_bus.rready = 1;
      lsu_bus.awvalid = 0; lsu_bus.awid = 0; lsu_bus.awaddr = 0; lsu_bus.awlen = 0;
      lsu_bus.awsize = 0; lsu_bus.awburst = 0; lsu_bus.wvalid = 0; lsu_bus.wdata = 0;
      lsu_bus.wstrb = 0; lsu_bus.wlast = 0; lsu_bus.bready = 1;
      io_bus.arready = 0; io_bus.rvalid = 0; io_bus.rid = 0; io_bus.rdata = 0;
      io_bus.rresp = 0; io_bus.rlast = 0; io_bus.awready = 0; io_bus.wready = 0;
      io_bus.bvalid = 0; io_bus.bid = 0; io_bus.bresp = 0;
      ifu_first = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ifu_first = 1'b1;
`endif

      // reset state, with a request pending that must not leak out
      step();
      ifu_rd_req(32'h8000_0000, 8'd3);
      step();
      check("rst_state", 32'(dut.state_q), 32'd0);
      check("rst_arvalid", 32'(io_bus.arvalid), 32'd0);
      check("rst_ifu_arready", 32'(ifu_bus.arready), 32'd0);
      check("rst_lsu_rvalid", 32'(lsu_bus.rvalid), 32'd0);
      rst = 1'b0;
      #1;
      check("idle_ifu_arready", 32'(ifu_bus.arready), 32'd0);

      // single IFU 4-beat burst
      serve_ar(1'b0, 32'h8000_0000, 8'd3);
      serve_r(1'b0, 8'd3, 32'h0000_1000, -1, 0);

      // IFU burst with rready stalled 5 cycles on beat 3
      ifu_rd_req(32'h8000_0100, 8'd3);
      serve_ar(1'b0, 32'h8000_0100, 8'd3);
      serve_r(1'b0, 8'd3, 32'h0000_2000, 2, 5);

      // simultaneous reads, last grant IFU: LSU first in both builds
      ifu_rd_req(32'h8000_0300, 8'd0);
      lsu_rd_req(32'h8000_0200, 8'd1);
      serve_ar(1'b1, 32'h8000_0200, 8'd1);
      serve_r(1'b1, 8'd1, 32'h0000_3000, -1, 0);
      serve_ar(1'b0, 32'h8000_0300, 8'd0);
      serve_r(1'b0, 8'd0, 32'h0000_3100, -1, 0);

      // single store
      lsu_bus.awvalid = 1'b1; lsu_bus.awaddr = 32'h8000_1000; lsu_bus.awsize = 3'b010;
      lsu_bus.wvalid  = 1'b1; lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wstrb = 4'hF;
      serve_wr(32'h8000_1000, 32'hDEAD_BEEF, 4'hF);

      // write and read together: write completes before the read is issued
      lsu_bus.awvalid = 1'b1; lsu_bus.awaddr = 32'h8000_1004; lsu_bus.awsize = 3'b010;
      lsu_bus.wvalid  = 1'b1; lsu_bus.wdata = 32'h1234_5678; lsu_bus.wstrb = 4'h3;
      lsu_rd_req(32'h8000_0400, 8'd0);
      serve_wr(32'h8000_1004, 32'h1234_5678, 4'h3);
      serve_ar(1'b1, 32'h8000_0400, 8'd0);
      serve_r(1'b1, 8'd0, 32'h0000_4000, -1, 0);

      // simultaneous reads, last grant LSU: fixed priority LSU, round-robin IFU
      ifu_rd_req(32'h8000_0600, 8'd1);
      lsu_rd_req(32'h8000_0500, 8'd1);
      if (ifu_first) begin
         serve_ar(1'b0, 32'h8000_0600, 8'd1);
         serve_r(1'b0, 8'd1, 32'h0000_4600, -1, 0);
         serve_ar(1'b1, 32'h8000_0500, 8'd1);
         serve_r(1'b1, 8'd1, 32'h0000_4500, -1, 0);
      end else begin
         serve_ar(1'b1, 32'h8000_0500, 8'd1);
         serve_r(1'b1, 8'd1, 32'h0000_4500, -1, 0);
         serve_ar(1'b0, 32'h8000_0600, 8'd1);
         serve_r(1'b0, 8'd1, 32'h0000_4600, -1, 0);
      end

      // reset during beat 2 of an IFU burst, then a fresh LSU read
      ifu_rd_req(32'h8000_0700, 8'd3);
      serve_ar(1'b0, 32'h8000_0700, 8'd3);
      io_bus.rvalid = 1'b1; io_bus.rdata = 32'h0000_5000; io_bus.rlast = 1'b0;
      #1;
      check("pre_rst_rdata", ifu_bus.rdata, 32'h0000_5000);
      step();
      io_bus.rdata = 32'h0000_5001;
      rst = 1'b1;
      #1;
      check("rst_same_rvalid", 32'(ifu_bus.rvalid), 32'd0);
      check("rst_same_rready", 32'(io_bus.rready), 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("post_rst_state", 32'(dut.state_q), 32'd0);
      check("post_rst_ifu_rvalid", 32'(ifu_bus.rvalid), 32'd0);
      check("post_rst_lsu_rvalid", 32'(lsu_bus.rvalid), 32'd0);
      check("post_rst_arvalid", 32'(io_bus.arvalid), 32'd0);
      step();
      check("post_rst_ifu_rvalid2", 32'(ifu_bus.rvalid), 32'd0);
      check("post_rst_rready2", 32'(io_bus.rready), 32'd0);
      io_bus.rvalid = 1'b0;
      lsu_rd_req(32'h8000_2000, 8'd2);
      serve_ar(1'b1, 32'h8000_2000, 8'd2);
      serve_r(1'b1, 8'd2, 32'h0000_6000, -1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 Parameters: none; all widths fixed (address 32, data 32, len 8, id 4).
REQ-002 clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ifu_ar{valid,addr,len,burst}  input  1/32/8/2  IFU read address; ifu_arready output 1.
REQ-005 ifu_r{data,resp,last,valid}  output  32/2/1/1  IFU read data; ifu_rready input 1.
REQ-006 lsu_ar{valid,addr,len,size,burst}  input  1/32/8/3/2  LSU read address; lsu_arready output 1.
REQ-007 lsu_r{data,resp,last,valid}  output  32/2/1/1  LSU read data; lsu_rready input 1.
REQ-008 lsu_aw{valid,addr,size}  input  1/32/3; lsu_w{valid,data,strb}  input  1/32/4; lsu_awready, lsu_wready  output  1; lsu_b{valid,resp}  output  1/2; lsu_bready  input  1.
REQ-009 io_master_* AXI4 master port  mixed  standard widths  single downstream port to the memory/bus slave; awid/arid driven 0, wlast driven 1, awlen 0, awburst 2'b01.

Function
REQ-010 FSM states IDLE, RD_IFU, RD_LSU, WR_LSU; exactly one transaction outstanding downstream at any time.
REQ-011 IDLE: every io_master valid/ready output 0; every upstream ready/valid output 0.
REQ-012 IDLE arbitration (registered, one cycle): lsu_awvalid -> WR_LSU; else lsu_arvalid -> RD_LSU; else ifu_arvalid -> RD_IFU; else stay IDLE.
REQ-013 RD_x: granted master's AR bundle passes combinationally to io_master_ar*; io_master_arready returns to that master's arready; io_master_arvalid held 0 after AR handshake until state exit.
REQ-014 RD_x: io_master_r* routed to granted master; io_master_rready = granted master's rready; non-granted master sees rvalid 0.
REQ-015 RD_x exits to IDLE on io_master_rvalid & rready & rlast; bursts (arlen up to 255, INCR) pass through beat by beat unmodified.
REQ-016 WR_LSU: AW and W channels pass through combinationally; each valid output forced 0 after its own handshake; io_master_bready = lsu_bready.
REQ-017 WR_LSU exits to IDLE on io_master_bvalid & bready.
REQ-018 Non-granted master's arready/awready/wready held 0; its requests stay pending, never dropped.
REQ-019 Minimum turnaround: one IDLE cycle between back-to-back transactions.
REQ-020 Responses (rresp, bresp) forwarded unmodified; no error generation.

Reset
REQ-021 Reset forces IDLE, clears handshake-done flags and priority pointer (LSU first), all outputs 0 in the same cycle.
REQ-022 Reset mid-transaction abandons it; no further beats forwarded to either master.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN defined: reads use a 1-bit last-grant pointer; on simultaneous lsu_arvalid and ifu_arvalid, grant goes to the master not granted last; writes still win over reads.
REQ-024 ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-012; pointer logic absent.

Verification
REQ-025 IFU only, araddr 0x80000000 arlen 3 INCR -> four beats forwarded, ifu_rlast on beat 4, FSM back to IDLE next cycle.
REQ-026 IFU and LSU arvalid same cycle, no macro -> LSU read granted first, IFU granted after LSU rlast; with macro and prior IFU grant, identical result; prior LSU grant -> IFU first.
REQ-027 LSU store awaddr 0x80001000 wdata 0xDEADBEEF wstrb 0xF -> single AW and W handshake downstream, lsu_bvalid once, bresp 0.
REQ-028 LSU awvalid and arvalid same cycle -> write completes (B handshake) before AR issued.
REQ-029 Reset asserted during beat 2 of a 4-beat IFU burst -> next cycle all valids 0, FSM IDLE, fresh LSU read then completes normally.
REQ-030 ifu_rready held 0 for 5 cycles mid-burst -> io_master_rready 0 for those cycles, no beat lost or duplicated.
